l1_mem_responder: RTL and testbench

L1_MEM_RESPONDER -- requirements
Module: l1_mem_responder

---
 rtl/l1_mem_responder_if.sv | 27 ++
 rtl/l1_mem_responder.sv | 71 +++++++
 tb/tb_l1_mem_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/l1_mem_responder_if.sv
// l1_mem_responder_if: CPU-side request/response and backing-memory signals of the L1 responder.
interface l1_mem_responder_if;
   logic        p_l1_read;
   logic        p_l1_write;
   logic [31:0] p_l1_addr;
   logic [1:0]  p_l1_write_type;
   logic [31:0] p_l1_write_data;
   logic        l1_stall;
   logic        l1_done;
   logic        l1_fault;
   logic [31:0] l1_read_data;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   modport slave (
      input  p_l1_read, p_l1_write, p_l1_addr, p_l1_write_type, p_l1_write_data, mem_ack, mem_rdata,
      output l1_stall, l1_done, l1_fault, l1_read_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
   modport master (
      output p_l1_read, p_l1_write, p_l1_addr, p_l1_write_type, p_l1_write_data, mem_ack, mem_rdata,
      input  l1_stall, l1_done, l1_fault, l1_read_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/l1_mem_responder.sv
// l1_mem_responder: turns single CPU load/store requests into one backing-memory transaction with timeout.
module l1_mem_responder #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic sys_clk,
   input logic rst,
   l1_mem_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic we_q, flt_q;
   logic [29:0] addr_q;
   logic [3:0] be_q, be_c;
   logic [31:0] wdata_q, wdata_c, rdata_q;
   logic valid, bad, timeout, rd, wr;
   logic [1:0] wt;
   logic [31:0] a, d;
   always_comb begin
      rd = bus.p_l1_read;
      wr = bus.p_l1_write;
      wt = bus.p_l1_write_type;
      a = bus.p_l1_addr;
      d = bus.p_l1_write_data;
      valid = rd | wr;
      bad = (rd & wr) | (wr & ((wt == 2'b10) | ((wt == 2'b01) & a[0]) | ((wt == 2'b11) & (|a[1:0]))));
      be_c = !wr ? 4'hf : wt == 2'b00 ? 4'b0001 << a[1:0] : wt == 2'b01 ? (a[1] ? 4'hc : 4'h3) : 4'hf;
      wdata_c = !wr ? 32'h0 : wt == 2'b00 ? {4{d[7:0]}} : wt == 2'b01 ? {2{d[15:0]}} : d;
      timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
      state_nx = state == IDLE ? (valid ? (bad ? DONE : REQ) : IDLE) :
                 state == REQ  ? ((bus.mem_ack | timeout) ? DONE : REQ) : IDLE;
   end
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         we_q <= 1'b0;
         flt_q <= 1'b0;
         addr_q <= '0;
         be_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nx;
         cnt <= state == REQ ? cnt + 1'b1 : '0;
         if (state == IDLE && valid) begin
            we_q <= wr;
            addr_q <= a[31:2];
            be_q <= be_c;
            wdata_q <= wdata_c;
            flt_q <= bad;
         end
         // ack wins over a timeout landing in the same cycle
         if (state == REQ && (bus.mem_ack | timeout)) begin
            flt_q <= !bus.mem_ack;
            if (!bus.mem_ack) rdata_q <= '0;
            else if (!we_q) rdata_q <= bus.mem_rdata;
         end
      end
   end
   assign bus.l1_stall = (state == IDLE && valid) || state == REQ;
   assign bus.l1_done = state == DONE;
   assign bus.l1_fault = state == DONE && flt_q;
   assign bus.l1_read_data = rdata_q;
   assign bus.mem_req = state == REQ;
   assign bus.mem_we = state == REQ && we_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_be = state == REQ ? be_q : 4'h0;
   assign bus.mem_wdata = state == REQ ? wdata_q : 32'h0;
endmodule

// File: tb/tb_l1_mem_responder.sv
// tb_l1_mem_responder: directed transactions against a cycle-offset model of the responder.
module tb_l1_mem_responder;
   localparam int T = 4;
   logic sys_clk = 1'b0;
   logic rst = 1'b1;
   always #5 sys_clk = ~sys_clk;
   l1_mem_responder_if bus();
   l1_mem_responder #(.TIMEOUT_CYCLES(T)) dut (.sys_clk(sys_clk), .rst(rst), .bus(bus));
   typedef struct {
      logic rd;
      logic wr;
      logic [31:0] addr;
      logic [1:0] wt;
      logic [31:0] data;
      int ack_k;
      logic [31:0] rdata;
   } txn_t;
   int cyc = 0, n_chk = 0, n_fail = 0, s = 0;
   txn_t t;
   bit txn_on = 0, chk_on = 0;
   logic [31:0] exp_rd = 0;
   int stall_n, req_n, done_n, done_k;
   logic [3:0] cap_be;
   logic [31:0] cap_wdata, cap_rd;
   logic [29:0] cap_addr;
   logic cap_we, cap_flt;
   always @(posedge sys_clk) cyc <= cyc + 1;
   function automatic bit m_fault(txn_t x);
      return (x.rd && x.wr) || (x.wr && (x.wt == 2'b10 || (x.wt == 2'b01 && x.addr[0]) || (x.wt == 2'b11 && x.addr[1:0] != 2'b00)));
   endfunction
   function automatic int m_size(txn_t x);
      return !x.wr ? 4 : x.wt == 2'b00 ? 1 : x.wt == 2'b01 ? 2 : 4;
   endfunction
   // lanes covered by an access of m_size bytes, aligned down inside the word
   function automatic logic [3:0] m_be(txn_t x);
      int sz = m_size(x);
      int lo = int'(x.addr[1:0]) / sz * sz;
      return 4'(((1 << sz) - 1) << lo);
   endfunction
   function automatic logic [31:0] m_wdata(txn_t x);
      logic [31:0] w;
      int sz = m_size(x);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = x.data[8*(i % sz) +: 8];
      return w;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask
   task automatic next_cycle;
      @(posedge sys_clk);
      #1;
   endtask
   always @(negedge sys_clk) begin
      logic e_stall, e_req, e_done, e_flt;
      int k, L;
      bit f, to;
      if (chk_on) begin
         e_stall = bus.p_l1_read | bus.p_l1_write;
         e_req = 0;
         e_done = 0;
         e_flt = 0;
         k = cyc - s;
         if (txn_on) begin
            f = m_fault(t);
            to = !(t.ack_k >= 1 && t.ack_k <= T);
            L = to ? T : t.ack_k;
            if (k == 0) begin
               stall_n = 0;
               req_n = 0;
               done_n = 0;
               done_k = -1;
            end
            if (f) begin
               e_stall = k == 0;
               e_done = k == 1;
               e_flt = 1;
            end else begin
               e_stall = k <= L;
               e_req = k >= 1 && k <= L;
               e_done = k == L + 1;
               e_flt = to;
               if (e_done) exp_rd = to ? 32'h0 : t.wr ? exp_rd : t.rdata;
            end
         end
         chk("l1_stall", bus.l1_stall, e_stall);
         chk("l1_done", bus.l1_done, e_done);
         if (e_done) chk("l1_fault", bus.l1_fault, e_flt);
         chk("mem_req", bus.mem_req, e_req);
         if (e_req) begin
            chk("mem_we", bus.mem_we, t.wr);
            chk("mem_addr", bus.mem_addr, t.addr[31:2]);
            chk("mem_be", bus.mem_be, m_be(t));
            if (t.wr) chk("mem_wdata", bus.mem_wdata, m_wdata(t));
         end else begin
            chk("mem_we_idle", bus.mem_we, 0);
            chk("mem_be_idle", bus.mem_be, 0);
            chk("mem_wdata_idle", bus.mem_wdata, 0);
         end
         chk("l1_read_data", bus.l1_read_data, exp_rd);
         stall_n += int'(bus.l1_stall);
         if (bus.mem_req) begin
            req_n++;
            cap_be = bus.mem_be;
            cap_wdata = bus.mem_wdata;
            cap_addr = bus.mem_addr;
            cap_we = bus.mem_we;
         end
         if (bus.l1_done) begin
            done_n++;
            done_k = k;
            cap_flt = bus.l1_fault;
            cap_rd = bus.l1_read_data;
         end
         if (rst) exp_rd = 0;
      end
   end
   task automatic run(input logic rd, input logic wr, input logic [31:0] addr, input logic [1:0] wt,
                      input logic [31:0] data, input int ack_k, input logic [31:0] rdata, input int rst_k);
      int L, last;
      next_cycle();
      bus.p_l1_read = rd;
      bus.p_l1_write = wr;
      bus.p_l1_addr = addr;
      bus.p_l1_write_type = wt;
      bus.p_l1_write_data = data;
      t = '{rd, wr, addr, wt, data, ack_k, rdata};
      s = cyc;
      txn_on = 1;
      L = (ack_k >= 1 && ack_k <= T) ? ack_k : T;
      last = rst_k >= 0 ? rst_k : m_fault(t) ? 1 : L + 1;
      for (int k = 1; k <= last; k++) begin
         next_cycle();
         // the held request's fields must not leak into the captured transaction
         bus.p_l1_addr = addr + 32'h10;
         bus.p_l1_write_data = ~data;
         bus.p_l1_write_type = ~wt;
         bus.mem_ack = (k == ack_k) || (k == last && rst_k < 0);
         bus.mem_rdata = k == ack_k ? rdata : 32'hBAD0_0000 | k;
         if (k == last && rst_k >= 0) rst = 1;
         if (k == last && rst_k < 0) begin
            bus.p_l1_read = 0;
            bus.p_l1_write = 0;
         end
      end
      next_cycle();
      txn_on = 0;
      bus.mem_ack = 0;
      if (rst_k >= 0) begin
         rst = 0;
         bus.p_l1_read = 0;
         bus.p_l1_write = 0;
         bus.mem_ack = 1;
         bus.mem_rdata = 32'hFEED_FACE;
         next_cycle();
         bus.mem_ack = 0;
         next_cycle();
      end
   endtask
   initial begin
      bus.p_l1_read = 0;
      bus.p_l1_write = 0;
      bus.p_l1_addr = 0;
      bus.p_l1_write_type = 0;
      bus.p_l1_write_data = 0;
      bus.mem_ack = 0;
      bus.mem_rdata = 0;
      next_cycle();
      chk_on = 1;
      next_cycle();
      bus.p_l1_read = 1;
      next_cycle();
      bus.p_l1_read = 0;
      rst = 0;
      next_cycle();
      run(0, 1, 32'h100, 2'b11, 32'hDEADBEEF, 2, 0, -1);
      chk("sw_addr", cap_addr, 32'h40);
      chk("sw_be", cap_be, 4'hf);
      chk("sw_we", cap_we, 1);
      chk("sw_stall_cycles", stall_n, 3);
      chk("sw_done_count", done_n, 1);
      chk("sw_fault", cap_flt, 0);
      run(0, 1, 32'h103, 2'b00, 32'h000000AB, 1, 0, -1);
      chk("sb_be", cap_be, 4'b1000);
      chk("sb_wdata", cap_wdata, 32'hABABABAB);
      run(0, 1, 32'h102, 2'b01, 32'h00001234, 1, 0, -1);
      chk("sh_be", cap_be, 4'b1100);
      chk("sh_wdata", cap_wdata, 32'h12341234);
      run(0, 1, 32'h100, 2'b01, 32'h0000BEEF, 3, 0, -1);
      chk("sh_lo_be", cap_be, 4'b0011);
      run(0, 1, 32'h101, 2'b00, 32'h00000077, 1, 0, -1);
      chk("sb_lane1_be", cap_be, 4'b0010);
      run(1, 0, 32'h106, 2'b00, 0, 1, 32'h12345678, -1);
      chk("rd_addr", cap_addr, 32'h41);
      chk("rd_be", cap_be, 4'hf);
      chk("rd_data", cap_rd, 32'h12345678);
      chk("rd_latency", done_k, 2);
      run(0, 1, 32'h101, 2'b01, 1, 0, 0, -1);
      chk("flt_sh_req", req_n, 0);
      chk("flt_sh_fault", cap_flt, 1);
      chk("flt_sh_latency", done_k, 1);
      run(0, 1, 32'h102, 2'b11, 1, 0, 0, -1);
      chk("flt_sw_req", req_n, 0);
      chk("flt_sw_fault", cap_flt, 1);
      run(0, 1, 32'h100, 2'b10, 1, 0, 0, -1);
      chk("flt_t10_req", req_n, 0);
      chk("flt_t10_done", done_n, 1);
      run(1, 1, 32'h100, 2'b11, 1, 0, 0, -1);
      chk("flt_rw_req", req_n, 0);
      chk("flt_rw_fault", cap_flt, 1);
      chk("rd_hold", bus.l1_read_data, 32'h12345678);
      run(1, 0, 32'h010, 2'b00, 0, 0, 0, -1);
      chk("to_req_cycles", req_n, T);
      chk("to_fault", cap_flt, 1);
      chk("to_rdata", cap_rd, 0);
      run(0, 1, 32'h020, 2'b11, 32'h55, T + 1, 0, -1);
      chk("to_wr_req_cycles", req_n, T);
      chk("to_wr_fault", cap_flt, 1);
      run(1, 0, 32'h200, 2'b00, 0, 0, 0, 2);
      chk("rst_no_done", done_n, 0);
      chk("rst_req_cycles", req_n, 2);
      run(1, 0, 32'h204, 2'b00, 0, 3, 32'hCAFEF00D, -1);
      chk("post_rst_fault", cap_flt, 0);
      chk("post_rst_rdata", cap_rd, 32'hCAFEF00D);
      next_cycle();
      next_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end
endmodule
